// File: rtl/vga_scanout_if.sv
// Framebuffer read port plus VGA DAC/sync pins of the scanout engine.
// master = scanout engine, slave = framebuffer RAM / DAC side.
interface vga_scanout_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_en;
    logic [7:0]        fb_data;
    logic [2:0]        red;
    logic [2:0]        green;
    logic [1:0]        blue;
    logic              hsync;
    logic              vsync;
    logic              blank;
    logic              frame_start;

    modport master (
        output fb_addr, fb_en, red, green, blue, hsync, vsync, blank, frame_start,
        input  fb_data
    );

    modport slave (
        input  fb_addr, fb_en, red, green, blue, hsync, vsync, blank, frame_start,
        output fb_data
    );
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout with 4x4 pixel replication; counter position to pins is 3 clks.
// Free-running: no backpressure, the RAM read port must answer every clk.
module vga_scanout #(
    parameter int ADDR_W  = 15,
    parameter int FB_COLS = 160,
    parameter int FB_ROWS = 120
) (
    input  logic          clk,
    input  logic          rst,
    vga_scanout_if.master vga
);
    localparam int H_VIS     = FB_COLS * 4;
    localparam int H_SYNC_S  = H_VIS + 16;
    localparam int H_SYNC_E  = H_SYNC_S + 96;
    localparam int H_TOTAL   = H_SYNC_E + 48;
    localparam int V_VIS     = FB_ROWS * 4;
    localparam int V_SYNC_S  = V_VIS + 10;
    localparam int V_SYNC_E  = V_SYNC_S + 2;
    localparam int V_TOTAL   = V_SYNC_E + 33;
    localparam int H_W       = $clog2(H_TOTAL);
    localparam int V_W       = $clog2(V_TOTAL);
    localparam int COL_W     = $clog2(FB_COLS + 1);

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic fs;
    } flags_t;

    localparam flags_t FLAGS_RST = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

    logic [H_W-1:0]    h_cnt_q, h_cnt_d;
    logic [V_W-1:0]    v_cnt_q, v_cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              fb_en_q, fb_en_d;
    flags_t            flg_s1_q, flg_s1_d;
    flags_t            flg_s2_q, flg_s2_d;
    logic [2:0]        red_q, red_d;
    logic [2:0]        green_q, green_d;
    logic [1:0]        blue_q, blue_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              blank_q, blank_d;
    logic              frame_start_q, frame_start_d;

    logic   h_wrap;
    logic   v_wrap;
    flags_t flg_s0;

    always_comb begin
        h_wrap     = (h_cnt_q == H_W'(H_TOTAL - 1));
        v_wrap     = (v_cnt_q == V_W'(V_TOTAL - 1));

        flg_s0.vis = (h_cnt_q < H_W'(H_VIS)) && (v_cnt_q < V_W'(V_VIS));
        flg_s0.hs  = !((h_cnt_q >= H_W'(H_SYNC_S)) && (h_cnt_q < H_W'(H_SYNC_E)));
        flg_s0.vs  = !((v_cnt_q >= V_W'(V_SYNC_S)) && (v_cnt_q < V_W'(V_SYNC_E)));
        flg_s0.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);

        h_cnt_d    = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d    = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end

        // Address = row_base + column, so the v/4 * FB_COLS product is never formed.
        col_d = col_q;
        if (h_wrap) begin
            col_d = '0;
        end else if (flg_s0.vis && (h_cnt_q[1:0] == 2'd3)) begin
            col_d = col_q + 1'b1;
        end

        row_base_d = row_base_q;
        if (h_wrap) begin
            if (v_wrap) begin
                row_base_d = '0;
            end else if (v_cnt_q[1:0] == 2'd3) begin
                row_base_d = row_base_q + ADDR_W'(FB_COLS);
            end
        end

        fb_en_d   = flg_s0.vis;
        fb_addr_d = flg_s0.vis ? row_base_q + ADDR_W'(col_q) : fb_addr_q;

        flg_s1_d  = flg_s0;
        flg_s2_d  = flg_s1_q;

        red_d         = flg_s2_q.vis ? vga.fb_data[7:5] : 3'd0;
        green_d       = flg_s2_q.vis ? vga.fb_data[4:2] : 3'd0;
        blue_d        = flg_s2_q.vis ? vga.fb_data[1:0] : 2'd0;
        hsync_d       = flg_s2_q.hs;
        vsync_d       = flg_s2_q.vs;
        blank_d       = !flg_s2_q.vis;
        frame_start_d = flg_s2_q.fs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            col_q         <= '0;
            row_base_q    <= '0;
            fb_addr_q     <= '0;
            fb_en_q       <= 1'b0;
            flg_s1_q      <= FLAGS_RST;
            flg_s2_q      <= FLAGS_RST;
            red_q         <= 3'd0;
            green_q       <= 3'd0;
            blue_q        <= 2'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            col_q         <= col_d;
            row_base_q    <= row_base_d;
            fb_addr_q     <= fb_addr_d;
            fb_en_q       <= fb_en_d;
            flg_s1_q      <= flg_s1_d;
            flg_s2_q      <= flg_s2_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.fb_addr     = fb_addr_q;
    assign vga.fb_en       = fb_en_q;
    assign vga.red         = red_q;
    assign vga.green       = green_q;
    assign vga.blue        = blue_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.blank       = blank_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced framebuffer so several whole frames fit in a short run.
// Reference model works from absolute frame position; a monitor drains its expectations each clk.
module tb_vga_scanout;
    localparam int AW    = 15;
    localparam int COLS  = 16;
    localparam int ROWS  = 8;
    localparam int HV    = COLS * 4;
    localparam int HT    = HV + 16 + 96 + 48;
    localparam int VV    = ROWS * 4;
    localparam int VT    = VV + 10 + 2 + 33;
    localparam int FRAME = HT * VT;
    localparam int NPIX  = COLS * ROWS;
    localparam int TARGET = 20 * HT + HV + 40;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          en;
        logic [2:0]    r;
        logic [2:0]    g;
        logic [1:0]    b;
        logic          hs;
        logic          vs;
        logic          bl;
        logic          fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_scanout_if #(.ADDR_W(AW)) vif ();

    vga_scanout #(.ADDR_W(AW), .FB_COLS(COLS), .FB_ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .vga (vif)
    );

    logic [7:0] mem [NPIX];

    always @(posedge clk) begin
        if (vif.fb_en) vif.fb_data <= mem[int'(vif.fb_addr) % NPIX];
    end

    int checks = 0;
    int errors = 0;

    obs_t          exp_q[$];
    int            m_pos = 0;
    int            m_age = 0;
    logic [AW-1:0] m_last = '0;
    bit            meas_abort = 1'b0;

    function automatic obs_t rst_out(input logic [AW-1:0] addr, input logic en);
        obs_t e;
        e = '0;
        e.addr = addr;
        e.en = en;
        e.hs = 1'b1;
        e.vs = 1'b1;
        e.bl = 1'b1;
        return e;
    endfunction

    function automatic obs_t pixel_out(input int q, input logic [AW-1:0] addr, input logic en);
        obs_t e;
        int x, y;
        logic [7:0] d;
        x = q % HT;
        y = q / HT;
        e = '0;
        e.addr = addr;
        e.en = en;
        if (x < HV && y < VV) begin
            d = mem[(y / 4) * COLS + x / 4];
            e.r = d[7:5];
            e.g = d[4:2];
            e.b = d[1:0];
            e.bl = 1'b0;
        end else begin
            e.bl = 1'b1;
        end
        e.hs = !(x >= HV + 16 && x < HV + 112);
        e.vs = !(y >= VV + 10 && y < VV + 12);
        e.fs = (q == 0);
        return e;
    endfunction

    // Expected pin state after each edge: fetch port reflects this edge's position,
    // colour/sync pins reflect the position two edges earlier.
    always @(posedge clk) begin : model
        int x, y;
        logic vis;
        obs_t e;
        if (rst) begin
            m_pos = 0;
            m_age = 0;
            m_last = '0;
            meas_abort = 1'b1;
            e = rst_out('0, 1'b0);
        end else begin
            x = m_pos % HT;
            y = m_pos / HT;
            vis = (x < HV) && (y < VV);
            if (vis) m_last = AW'((y / 4) * COLS + x / 4);
            if (m_age >= 2) e = pixel_out((m_pos + FRAME - 2) % FRAME, m_last, vis);
            else            e = rst_out(m_last, vis);
            m_pos = (m_pos + 1) % FRAME;
            m_age++;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        obs_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.addr = vif.fb_addr;
            a.en   = vif.fb_en;
            a.r    = vif.red;
            a.g    = vif.green;
            a.b    = vif.blue;
            a.hs   = vif.hsync;
            a.vs   = vif.vsync;
            a.bl   = vif.blank;
            a.fs   = vif.frame_start;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scoreboard @%0t got addr=%0d en=%b rgb=%h/%h/%h hs=%b vs=%b bl=%b fs=%b exp addr=%0d en=%b rgb=%h/%h/%h hs=%b vs=%b bl=%b fs=%b",
                         $time, a.addr, a.en, a.r, a.g, a.b, a.hs, a.vs, a.bl, a.fs,
                         e.addr, e.en, e.r, e.g, e.b, e.hs, e.vs, e.bl, e.fs);
            end
        end
    end

    bit have_fs = 1'b0;
    int cyc = 0, nb = 0, hl = 0, vl = 0;

    always @(negedge clk) begin : measure
        if (meas_abort) begin
            have_fs = 1'b0;
            meas_abort = 1'b0;
        end
        if (vif.frame_start === 1'b1) begin
            if (have_fs) begin
                checks += 4;
                if (cyc != FRAME) begin errors++; $display("FAIL frame_period got=%0d exp=%0d", cyc, FRAME); end
                if (nb != HV * VV) begin errors++; $display("FAIL visible_clks got=%0d exp=%0d", nb, HV * VV); end
                if (hl != 96 * VT) begin errors++; $display("FAIL hsync_low_clks got=%0d exp=%0d", hl, 96 * VT); end
                if (vl != 2 * HT) begin errors++; $display("FAIL vsync_low_clks got=%0d exp=%0d", vl, 2 * HT); end
            end
            have_fs = 1'b1;
            cyc = 0; nb = 0; hl = 0; vl = 0;
        end
        cyc++;
        if (vif.blank === 1'b0) nb++;
        if (vif.hsync === 1'b0) hl++;
        if (vif.vsync === 1'b0) vl++;
    end

    task automatic check_rst(input string tag);
        logic [AW+12:0] got, req;
        got = {vif.fb_addr, vif.fb_en, vif.red, vif.green, vif.blue,
               vif.hsync, vif.vsync, vif.blank, vif.frame_start};
        req = {{AW{1'b0}}, 1'b0, 8'h00, 4'b1110};
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s_reset_values got=%h exp=%h", tag, got, req);
        end
    endtask

    // Called at posedge+1 while rst is high; releases rst and follows the restart.
    task automatic release_check(input string tag);
        int n;
        n = 0;
        #1 rst = 1'b0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (vif.frame_start !== 1'b1 && n < 12);
        checks++;
        if (n != 3) begin errors++; $display("FAIL %s_fs_latency got=%0d exp=3", tag, n); end
        checks++;
        if (vif.blank !== 1'b0 || {vif.red, vif.green, vif.blue} !== 8'hE3) begin
            errors++;
            $display("FAIL %s_first_pixel got blank=%b rgb=%h exp blank=0 rgb=e3", tag, vif.blank,
                     {vif.red, vif.green, vif.blue});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({vif.red, vif.green, vif.blue} !== 8'hE3) begin
            errors++;
            $display("FAIL %s_pixel_hold got=%h exp=e3", tag, {vif.red, vif.green, vif.blue});
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE3;
    endtask

    initial begin : stim
        bit found;
        fill_mem();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_rst("por");
        release_check("por");

        repeat (2 * FRAME + 50) @(posedge clk);
        repeat ($urandom_range(100, 3000)) @(posedge clk);

        #2 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_rst("hold5");
        fill_mem();
        release_check("hold5");

        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk);
            #2;
            if (m_pos == TARGET) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_target_reach got=0 exp=1"); end
        rst = 1'b1;
        @(posedge clk);
        #1 check_rst("mid");
        release_check("mid");

        repeat (FRAME + 100) @(posedge clk);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Read-side scanout engine for the jml-8-mini-vga framebuffer. It generates 640x480@60 Hz VGA timing from the pixel clock and fetches one byte per visible pixel from the read port of the dual-port framebuffer RAM. Each framebuffer pixel is replicated 4x4, so the RAM holds a 160x120 image. The fetched bytes drive the RRRGGGBB DAC pins, with sync and blanking aligned to them.

## Interface
Parameters:
- ADDR_W, 15, width of framebuffer read address; equals the framebuffer read-address port width.
- FB_COLS, 160, framebuffer pixels per row.
- FB_ROWS, 120, framebuffer rows.

Ports:
- clk  in  1  pixel clock (25.175 MHz); only clock in the block.
- rst  in  1  synchronous, active-high reset.
- fb_addr  out  ADDR_W  framebuffer read address (r_addr).
- fb_en  out  1  framebuffer read enable (r_en).
- fb_data  in  8  framebuffer read data (r_data), registered in the RAM, valid 1 clk after fb_en.
- red  out  3  fb_data[7:5] when visible, else 0.
- green  out  3  fb_data[4:2] when visible, else 0.
- blue  out  2  fb_data[1:0] when visible, else 0.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- blank  out  1  high outside the visible 640x480 region.
- frame_start  out  1  one-clk pulse coincident with output pixel (0,0).

## Operation
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt runs 0..524 and increments only on the h_cnt wrap. v_cnt wraps 524→0 on the same edge that h_cnt wraps.
- Visible region: h_cnt<640 and v_cnt<480.
- Horizontal line: 640 visible, 16 front porch, 96 sync (h 656..751), 48 back porch.
- Vertical frame: 480 visible, 10 front porch, 2 sync (v 490..491), 33 back porch.
- Address:
  - fb_addr = (v_cnt>>2)*FB_COLS + (h_cnt>>2).
  - Computed without a multiplier: a row_base register adds FB_COLS when v_cnt[1:0]==3 at line wrap and clears at frame wrap. A column term increments every 4th visible clk.
- fb_en is 1 only for visible positions. fb_addr holds its last value when fb_en=0.
- Pipeline, with the counters at stage 0:
  - S1: fb_addr/fb_en registered.
  - S2: RAM returns fb_data.
  - S3: colour, sync, blank and frame_start output registers.
- Sync, blank and visibility flags are delayed through matched shift stages so all outputs describe the same pixel.
- Colour is forced to 0 whenever the delayed visible flag is 0, regardless of fb_data.
- Reset:
  - Counters go to (0,0), the pipeline flushes, and all outputs take their reset values on the next edge.
  - Reset values: fb_addr=0, fb_en=0, red/green/blue=0, hsync=1, vsync=1, blank=1, frame_start=0.
  - Reset asserted mid-frame aborts the frame. No partial sync pulse is extended.
  - Reset has priority over all counting.

## Timing
- Cycle 0 is the first clk edge with rst low. Counters are (0,0) during cycle 0.
- Cycle 1: fb_addr=0, fb_en=1.
- Cycle 2: fb_data for address 0.
- Cycle 3: red/green/blue for pixel (0,0), blank=0, frame_start=1.
- Latency from counter position to pin is exactly 3 clks, for colour, hsync, vsync, blank and frame_start alike.
- During pipeline fill (cycles 0-2 after reset), outputs keep their reset values.
- Line period: 800 clks. Frame period: 420000 clks. hsync low for 96 clks per line. vsync low for 1600 clks per frame.
- Address sequence on a line: each address is held 4 clks (0,0,0,0,1,1,1,1,…,159).
  - Lines 0-3 repeat addresses 0..159.
  - Line 4 starts at 160.
  - Line 479 ends at 19199.
  - Line 480 onward: fb_en=0 until frame wrap.

## Test plan
- Reset: hold rst 5 clks mid-frame → all outputs at reset values. Release → frame_start first high exactly 3 clks after the first rst-low edge, blank=0 the same clk.
- Address walk: RAM model returns the low address byte. Check the fb_addr sequence:
  - line 0 holds each value 4 clks, 0..159;
  - line 3 still starts at 0; line 4 starts at 160; line 479 ends at 19199;
  - fb_en=0 for h 640..799 and for v≥480.
- Colour mapping: RAM word at address 0 = 0xE3 → red=7, green=0, blue=3 on the frame_start clk, held 4 clks.
- Blanking: RAM returns 0xFF everywhere → red/green/blue=0 whenever blank=1. Exactly 640 non-blank clks per visible line, 480 visible lines.
- Sync timing: measure over two frames.
  - hsync: period 800, low width 96, falling edge 656 clks after the line's first non-blank clk.
  - vsync: period 420000, low width 1600, falling edge 490 lines after frame_start.
- Mid-frame reset: assert rst at line 300, h=700 for 1 clk → next edge all outputs at reset values, and restart matches the reset scenario exactly.
